// File: rtl/hqm_reorder_pipe_flr_pkg.sv
// hqm_reorder_pipe_flr_pkg: shared types and interface indices for the rop FLR quiesce controller
package hqm_reorder_pipe_flr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        PREP  = 2'd2,
        HOLD  = 2'd3
    } flr_state_t;

    localparam int ROP_FLR_NUM_IF        = 7;
    localparam int ROP_IF_ALARM          = 0;
    localparam int ROP_IF_CFG_RD         = 1;
    localparam int ROP_IF_CFG_WR         = 2;
    localparam int ROP_IF_DP_ENQ         = 3;
    localparam int ROP_IF_NALB_ENQ       = 4;
    localparam int ROP_IF_QED_DQED_ENQ   = 5;
    localparam int ROP_IF_LSP_REORDERCMP = 6;

endpackage

// File: rtl/hqm_AW_sat_cnt.sv
// hqm_AW_sat_cnt: saturating up-counter with synchronous clear (clear wins over increment)
module hqm_AW_sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // count up until all-ones, then hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hqm_reorder_pipe_flr_quiesce.sv
// hqm_reorder_pipe_flr_quiesce: drains rop outbound interfaces on FLR, then raises prep and acks
module hqm_reorder_pipe_flr_quiesce
    import hqm_reorder_pipe_flr_pkg::*;
#(
    parameter int NUM_IF   = ROP_FLR_NUM_IF,
    parameter int IDLE_CYC = 16,
    parameter int TMO_W    = 16
) (
    input  logic              hqm_gated_clk,
    input  logic              hqm_gated_rst_n,
    input  logic              flr_req,
    input  logic [NUM_IF-1:0] if_v,
    input  logic [NUM_IF-1:0] if_ready,
    input  logic              pipe_idle,
    input  logic [TMO_W-1:0]  cfg_drain_timeout,
    output logic              flr_prep,
    output logic              flr_ack,
    output logic              flr_tmo_err,
    output logic [NUM_IF-1:0] flr_blocked_if,
    output logic [1:0]        flr_state
);

    localparam int IW = $clog2(IDLE_CYC + 1);

    flr_state_t        r_state;
    flr_state_t        w_next;
    logic              r_prep;
    logic              r_ack;
    logic              r_tmo_err;
    logic [NUM_IF-1:0] r_blocked;
    logic [IW-1:0]     w_idle_cnt;
    logic [TMO_W-1:0]  w_tmo_cnt;
    logic [NUM_IF-1:0] w_stalled;
    logic [NUM_IF-1:0] w_xfer;
    logic              w_quiet;
    logic              w_drain;
    logic              w_entry;
    logic              w_done;
    logic              w_tmo;

    // a valid is busy whether it is stalled or transferring; ready never makes it quiet
    assign w_stalled = if_v & ~if_ready;
    assign w_xfer    = if_v & if_ready;
    assign w_quiet   = pipe_idle & ~|(w_stalled | w_xfer);
    assign w_drain   = (r_state == DRAIN);
    assign w_entry   = (r_state == IDLE) & flr_req;
    assign w_done    = w_drain & flr_req & w_quiet & (w_idle_cnt == IW'(IDLE_CYC - 1));
    assign w_tmo     = w_drain & flr_req & ~w_done & (|cfg_drain_timeout) &
                       (w_tmo_cnt == cfg_drain_timeout - TMO_W'(1));

    hqm_AW_sat_cnt #(.W(IW)) u_idle_cnt (
        .clk   (hqm_gated_clk),
        .rst_n (hqm_gated_rst_n),
        .clr   (w_entry | (w_drain & ~w_quiet)),
        .inc   (w_drain & w_quiet),
        .cnt   (w_idle_cnt)
    );

    hqm_AW_sat_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk   (hqm_gated_clk),
        .rst_n (hqm_gated_rst_n),
        .clr   (w_entry),
        .inc   (w_drain),
        .cnt   (w_tmo_cnt)
    );

    // next state: abort from DRAIN beats completion; PREP always settles one cycle into HOLD
    always_comb begin
        w_next = (r_state == IDLE)  ? (flr_req ? DRAIN : IDLE) :
                 (r_state == DRAIN) ? (!flr_req ? IDLE : (w_done | w_tmo) ? PREP : DRAIN) :
                 (r_state == PREP)  ? HOLD :
                                      (flr_req ? HOLD : IDLE);
    end

    // state and registered outputs, all derived from the next state so they align with it
    always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
        if (!hqm_gated_rst_n) begin
            r_state   <= IDLE;
            r_prep    <= 1'b0;
            r_ack     <= 1'b0;
            r_tmo_err <= 1'b0;
            r_blocked <= '0;
        end else begin
            r_state   <= w_next;
            r_prep    <= (w_next == PREP) | (w_next == HOLD);
            r_ack     <= (w_next == HOLD);
            r_tmo_err <= w_tmo;
            r_blocked <= w_entry ? '0 : w_tmo ? if_v : r_blocked;
        end
    end

    assign flr_prep       = r_prep;
    assign flr_ack        = r_ack;
    assign flr_tmo_err    = r_tmo_err;
    assign flr_blocked_if = r_blocked;
    assign flr_state      = r_state;

endmodule

// File: tb/tb_hqm_reorder_pipe_flr_quiesce.sv
// tb_hqm_reorder_pipe_flr_quiesce: scoreboard bench for the rop FLR quiesce controller
module tb_hqm_reorder_pipe_flr_quiesce;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flr_req = 1'b0;
    logic [6:0]  if_v = '0;
    logic [6:0]  if_ready = '1;
    logic        pipe_idle = 1'b1;
    logic [15:0] cfg = '0;
    logic        flr_prep;
    logic        flr_ack;
    logic        flr_tmo_err;
    logic [6:0]  flr_blocked_if;
    logic [1:0]  flr_state;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        int         prep_cyc;
        int         ack_cyc;
        int         err_cnt;
        int         err_cyc;
        logic [6:0] blocked;
    } res_t;

    res_t sbq[$];

    hqm_reorder_pipe_flr_quiesce dut (
        .hqm_gated_clk     (clk),
        .hqm_gated_rst_n   (rst_n),
        .flr_req           (flr_req),
        .if_v              (if_v),
        .if_ready          (if_ready),
        .pipe_idle         (pipe_idle),
        .cfg_drain_timeout (cfg),
        .flr_prep          (flr_prep),
        .flr_ack           (flr_ack),
        .flr_tmo_err       (flr_tmo_err),
        .flr_blocked_if    (flr_blocked_if),
        .flr_state         (flr_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // raise flr_req at cycle 0 and run until ack or budget; pat / pipe-busy applied in [w_from, w_to]
    task automatic run_req(input logic [6:0] pat, input logic pidle_low, input int w_from,
                           input int w_to, input int budget, output res_t o);
        bit win;
        o = '{-1, -1, 0, -1, 7'h0};
        cyc = 0;
        win = (w_from <= 0) && (0 <= w_to);
        if_v = win ? pat : 7'h0;
        pipe_idle = !(pidle_low && win);
        flr_req = 1'b1;
        while (o.ack_cyc < 0 && cyc < budget) begin
            step();
            if (flr_prep && o.prep_cyc < 0) o.prep_cyc = cyc;
            if (flr_ack && o.ack_cyc < 0) o.ack_cyc = cyc;
            if (flr_tmo_err) begin
                o.err_cnt++;
                o.err_cyc = cyc;
            end
            win = (w_from <= cyc) && (cyc <= w_to);
            if_v = win ? pat : 7'h0;
            pipe_idle = !(pidle_low && win);
        end
        o.blocked = flr_blocked_if;
        if_v = '0;
        pipe_idle = 1'b1;
    endtask

    task automatic release_req();
        flr_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({flr_prep, flr_ack, flr_tmo_err, flr_blocked_if, flr_state} !== 12'h0)
            $display("FAIL reset_outputs: got %h want 000",
                     {flr_prep, flr_ack, flr_tmo_err, flr_blocked_if, flr_state});
        else passed++;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({flr_prep, flr_ack, flr_state} !== 4'h0)
            $display("FAIL reset_idle_no_req: got %h want 0", {flr_prep, flr_ack, flr_state});
        else passed++;
    endtask

    task automatic test_quiet_drain();
        res_t o, e;
        sbq.push_back('{17, 18, 0, -1, 7'h0});
        run_req(7'h00, 1'b0, 1, 0, 60, o);
        e = sbq.pop_front();
        checks++;
        if (o.prep_cyc !== e.prep_cyc) $display("FAIL quiet_prep_cyc: got %0d want %0d", o.prep_cyc, e.prep_cyc);
        else passed++;
        checks++;
        if (o.ack_cyc !== e.ack_cyc) $display("FAIL quiet_ack_cyc: got %0d want %0d", o.ack_cyc, e.ack_cyc);
        else passed++;
        checks++;
        if (o.err_cnt !== e.err_cnt) $display("FAIL quiet_err_cnt: got %0d want %0d", o.err_cnt, e.err_cnt);
        else passed++;
        checks++;
        if (flr_state !== 2'd3) $display("FAIL quiet_hold_state: got %0d want 3", flr_state);
        else passed++;
        release_req();
    endtask

    task automatic test_if_busy();
        res_t o, e;
        sbq.push_back('{27, 28, 0, -1, 7'h0});
        run_req(7'h08, 1'b0, 1, 10, 60, o);
        e = sbq.pop_front();
        checks++;
        if (o.prep_cyc !== e.prep_cyc) $display("FAIL ifbusy_prep_cyc: got %0d want %0d", o.prep_cyc, e.prep_cyc);
        else passed++;
        checks++;
        if (o.ack_cyc !== e.ack_cyc) $display("FAIL ifbusy_ack_cyc: got %0d want %0d", o.ack_cyc, e.ack_cyc);
        else passed++;
        release_req();
    endtask

    task automatic test_pipe_busy();
        res_t o, e;
        sbq.push_back('{22, 23, 0, -1, 7'h0});
        run_req(7'h00, 1'b1, 1, 5, 60, o);
        e = sbq.pop_front();
        checks++;
        if (o.prep_cyc !== e.prep_cyc) $display("FAIL pipebusy_prep_cyc: got %0d want %0d", o.prep_cyc, e.prep_cyc);
        else passed++;
        checks++;
        if (o.ack_cyc !== e.ack_cyc) $display("FAIL pipebusy_ack_cyc: got %0d want %0d", o.ack_cyc, e.ack_cyc);
        else passed++;
        release_req();
    endtask

    task automatic test_quiet_vs_timeout();
        res_t o, e;
        cfg = 16'd16;
        sbq.push_back('{17, 18, 0, -1, 7'h0});
        run_req(7'h00, 1'b0, 1, 0, 60, o);
        e = sbq.pop_front();
        checks++;
        if (o.prep_cyc !== e.prep_cyc) $display("FAIL tie_prep_cyc: got %0d want %0d", o.prep_cyc, e.prep_cyc);
        else passed++;
        checks++;
        if (o.err_cnt !== e.err_cnt) $display("FAIL tie_err_cnt: got %0d want %0d", o.err_cnt, e.err_cnt);
        else passed++;
        release_req();
        cfg = '0;
    endtask

    task automatic test_timeout();
        res_t o, e;
        cfg = 16'd100;
        sbq.push_back('{101, 102, 1, 101, 7'h04});
        run_req(7'h04, 1'b0, 0, 1000000, 200, o);
        e = sbq.pop_front();
        checks++;
        if (o.prep_cyc !== e.prep_cyc) $display("FAIL tmo_prep_cyc: got %0d want %0d", o.prep_cyc, e.prep_cyc);
        else passed++;
        checks++;
        if (o.ack_cyc !== e.ack_cyc) $display("FAIL tmo_ack_cyc: got %0d want %0d", o.ack_cyc, e.ack_cyc);
        else passed++;
        checks++;
        if (o.err_cnt !== e.err_cnt) $display("FAIL tmo_err_cnt: got %0d want %0d", o.err_cnt, e.err_cnt);
        else passed++;
        checks++;
        if (o.err_cyc !== e.err_cyc) $display("FAIL tmo_err_cyc: got %0d want %0d", o.err_cyc, e.err_cyc);
        else passed++;
        checks++;
        if (o.blocked !== e.blocked) $display("FAIL tmo_blocked: got %h want %h", o.blocked, e.blocked);
        else passed++;
        release_req();
        checks++;
        if (flr_blocked_if !== 7'h04) $display("FAIL tmo_blocked_sticky: got %h want 04", flr_blocked_if);
        else passed++;
        flr_req = 1'b1;
        step();
        checks++;
        if ({flr_blocked_if, flr_state} !== {7'h00, 2'd1})
            $display("FAIL tmo_blocked_clear: got %h want %h", {flr_blocked_if, flr_state}, {7'h00, 2'd1});
        else passed++;
        release_req();
        cfg = '0;
    endtask

    task automatic test_abort();
        int seen = 0;
        cyc = 0;
        flr_req = 1'b1;
        repeat (5) step();
        checks++;
        if (flr_state !== 2'd1) $display("FAIL abort_drain_state: got %0d want 1", flr_state);
        else passed++;
        flr_req = 1'b0;
        step();
        checks++;
        if (flr_state !== 2'd0) $display("FAIL abort_idle_cyc6: got %0d want 0", flr_state);
        else passed++;
        repeat (30) begin
            step();
            if (flr_prep || flr_ack) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL abort_no_prep: got %0d want 0", seen);
        else passed++;
    endtask

    task automatic test_drop_in_prep();
        cyc = 0;
        flr_req = 1'b1;
        while (!flr_prep && cyc < 40) step();
        checks++;
        if (cyc !== 17) $display("FAIL prepdrop_prep_cyc: got %0d want 17", cyc);
        else passed++;
        flr_req = 1'b0;
        step();
        checks++;
        if ({flr_ack, flr_state} !== {1'b1, 2'd3}) $display("FAIL prepdrop_hold: got %h want 7", {flr_ack, flr_state});
        else passed++;
        step();
        checks++;
        if ({flr_prep, flr_ack, flr_state} !== 4'h0)
            $display("FAIL prepdrop_release: got %h want 0", {flr_prep, flr_ack, flr_state});
        else passed++;
    endtask

    task automatic test_hold_release();
        res_t o, e;
        sbq.push_back('{17, 18, 0, -1, 7'h0});
        run_req(7'h00, 1'b0, 1, 0, 60, o);
        e = sbq.pop_front();
        checks++;
        if (o.ack_cyc !== e.ack_cyc) $display("FAIL hold_ack_cyc: got %0d want %0d", o.ack_cyc, e.ack_cyc);
        else passed++;
        step();
        checks++;
        if ({flr_prep, flr_ack} !== 2'b11) $display("FAIL hold_stays: got %b want 11", {flr_prep, flr_ack});
        else passed++;
        flr_req = 1'b0;
        step();
        checks++;
        if ({flr_prep, flr_ack, flr_state} !== 4'h0)
            $display("FAIL hold_release: got %h want 0", {flr_prep, flr_ack, flr_state});
        else passed++;
        sbq.push_back('{17, 18, 0, -1, 7'h0});
        run_req(7'h00, 1'b0, 1, 0, 60, o);
        e = sbq.pop_front();
        checks++;
        if (o.prep_cyc !== e.prep_cyc) $display("FAIL rereq_prep_cyc: got %0d want %0d", o.prep_cyc, e.prep_cyc);
        else passed++;
    endtask

    task automatic test_reset_in_hold();
        checks++;
        if (flr_state !== 2'd3) $display("FAIL rst_pre_hold: got %0d want 3", flr_state);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({flr_prep, flr_ack, flr_tmo_err, flr_blocked_if, flr_state} !== 12'h0)
            $display("FAIL rst_async: got %h want 000", {flr_prep, flr_ack, flr_tmo_err, flr_blocked_if, flr_state});
        else passed++;
        flr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_timeout();
        int errs = 0;
        int preps = 0;
        cfg = '0;
        if_v = 7'h04;
        flr_req = 1'b1;
        repeat (10000) begin
            step();
            if (flr_tmo_err) errs++;
            if (flr_prep) preps++;
        end
        checks++;
        if (flr_state !== 2'd1) $display("FAIL notmo_state: got %0d want 1", flr_state);
        else passed++;
        checks++;
        if (errs !== 0) $display("FAIL notmo_err: got %0d want 0", errs);
        else passed++;
        checks++;
        if (preps !== 0) $display("FAIL notmo_prep: got %0d want 0", preps);
        else passed++;
        if_v = '0;
        release_req();
    endtask

    initial begin
        test_reset();
        test_quiet_drain();
        test_if_busy();
        test_pipe_busy();
        test_quiet_vs_timeout();
        test_timeout();
        test_abort();
        test_drop_in_prep();
        test_hold_release();
        test_reset_in_hold();
        test_no_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
